// File: rtl/fsm_pkg.sv
// Shared state encodings, counter width and helpers for the hit window monitor.
// Used by sat_counter and hit_window_monitor.
package fsm_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t WIN   = 2'b01;
    localparam state_t ALARM = 2'b10;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage : fsm_pkg

// File: rtl/sat_counter.sv
// Saturating CNT_W-bit event counter with synchronous clear.
// A clear together with an increment restarts the count at one.
module sat_counter
    import fsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            q_d = sat_inc(q_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : sat_counter

// File: rtl/hit_window_monitor.sv
// Fixed-window hit counter raising an alarm when THRESH hits land in WINDOW cycles.
// Build option: define ALARM_STICKY_EN to hold ALARM until clr or rst.
module hit_window_monitor
    import fsm_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic             clr,
    output logic             alarm,
    output logic             win_exp,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] total_hits,
    output logic             busy
);

    // The opening hit is window cycle 0, so the hit sampled with timer value t
    // belongs to window cycle t+1; the last window cycle is sampled at WINDOW-2.
    localparam logic [CNT_W-1:0] LAST_T   = CNT_W'(WINDOW - 2);
    localparam logic [CNT_W:0]   THRESH_V = (CNT_W + 1)'(THRESH);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;
    logic             win_exp_q;
    logic             win_exp_d;

    logic             win_clr;
    logic             win_inc;
    logic [CNT_W:0]   hits_next;
    logic             thresh_hit;
    logic             last_cycle;

    assign hits_next  = {1'b0, hit_cnt} + {{CNT_W{1'b0}}, hit};
    assign thresh_hit = (hits_next >= THRESH_V);
    assign last_cycle = (timer_q == LAST_T);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        win_exp_d = 1'b0;
        win_clr   = 1'b0;
        win_inc   = 1'b0;

        if (clr) begin
            state_d = IDLE;
            timer_d = '0;
            win_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        state_d = WIN;
                        timer_d = '0;
                        win_clr = 1'b1;
                        win_inc = 1'b1;
                    end
                end

                WIN: begin
                    timer_d = timer_q + CNT_W'(1);
                    win_inc = hit;
                    // Threshold beats expiry on the last window cycle.
                    if (thresh_hit) begin
                        state_d = ALARM;
                    end else if (last_cycle) begin
                        state_d   = IDLE;
                        timer_d   = '0;
                        win_clr   = 1'b1;
                        win_inc   = 1'b0;
                        win_exp_d = 1'b1;
                    end
                end

                ALARM: begin
`ifdef ALARM_STICKY_EN
                    state_d = ALARM;
`else
                    timer_d = '0;
                    win_clr = 1'b1;
                    if (hit) begin
                        state_d = WIN;
                        win_inc = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end

                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    win_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            win_exp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            win_exp_q <= win_exp_d;
        end
    end

    sat_counter u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (win_inc),
        .clr (win_clr),
        .q   (hit_cnt)
    );

    // A hit sampled together with clr is discarded.
    sat_counter u_total_hits (
        .clk (clk),
        .rst (rst),
        .inc (hit & ~clr),
        .clr (clr),
        .q   (total_hits)
    );

    assign alarm   = (state_q == ALARM);
    assign busy    = (state_q == WIN) || (state_q == ALARM);
    assign win_exp = win_exp_q;

endmodule : hit_window_monitor

// File: tb/tb_hit_window_monitor.sv
// Directed self-checking bench for hit_window_monitor (WINDOW=16, THRESH=3).
// Observed vector packs {alarm, win_exp, busy, hit_cnt, total_hits}.
module tb_hit_window_monitor;

    logic       clk;
    logic       rst;
    logic       hit;
    logic       clr;
    logic       alarm;
    logic       win_exp;
    logic [7:0] hit_cnt;
    logic [7:0] total_hits;
    logic       busy;

    logic [18:0] obs;
    int          checks;
    int          errors;

    hit_window_monitor #(.WINDOW(16), .THRESH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .hit        (hit),
        .clr        (clr),
        .alarm      (alarm),
        .win_exp    (win_exp),
        .hit_cnt    (hit_cnt),
        .total_hits (total_hits),
        .busy       (busy)
    );

    assign obs = {alarm, win_exp, busy, hit_cnt, total_hits};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive hit for one cycle; returns 1 time unit after the sampling edge.
    task automatic step(input logic h);
        hit = h;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        hit = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        hit = 1'b0;
        clr = 1'b0;
        #3;
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs, 19'd0);
        end
        hit = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL reset_hold_hit: got %h want %h", obs, 19'd0);
        end
        hit = 1'b0;
        rst = 1'b1;
        step(1'b1);
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL reset_first_edge: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 8'd1, 8'd1});
        end
        do_clr();
    endtask

    task automatic test_alarm();
        logic [18:0] exp;
        int          hc;
        hc = 0;
        do_clr();
        for (int c = 0; c <= 10; c++) begin
            step(c == 0 || c == 5 || c == 10);
            if (c == 0 || c == 5 || c == 10) hc++;
            exp = {(c == 10), 1'b0, 1'b1, 8'(hc), 8'(hc)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL alarm_window c=%0d: got %h want %h", c, obs, exp);
            end
        end
        step(1'b0);
`ifdef ALARM_STICKY_EN
        exp = {1'b1, 1'b0, 1'b1, 8'd3, 8'd3};
`else
        exp = {1'b0, 1'b0, 1'b0, 8'd0, 8'd3};
`endif
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL alarm_after: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_expire();
        logic [18:0] exp;
        int          hc;
        hc = 0;
        do_clr();
        for (int c = 0; c <= 15; c++) begin
            step(c == 0 || c == 8);
            if (c == 0 || c == 8) hc++;
            if (c == 15) exp = {1'b0, 1'b1, 1'b0, 8'd0, 8'd2};
            else         exp = {1'b0, 1'b0, 1'b1, 8'(hc), 8'(hc)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL expire_window c=%0d: got %h want %h", c, obs, exp);
            end
        end
        step(1'b1);
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 8'd1, 8'd3}) begin
            errors++;
            $display("FAIL expire_reopen: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 8'd1, 8'd3});
        end
    endtask

    task automatic test_last_cycle();
        logic [18:0] exp;
        do_clr();
        for (int c = 0; c <= 15; c++) begin
            step(c == 0 || c == 1 || c == 15);
            if (c == 0)       exp = {1'b0, 1'b0, 1'b1, 8'd1, 8'd1};
            else if (c < 15)  exp = {1'b0, 1'b0, 1'b1, 8'd2, 8'd2};
            else              exp = {1'b1, 1'b0, 1'b1, 8'd3, 8'd3};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL last_cycle c=%0d: got %h want %h", c, obs, exp);
            end
        end
        step(1'b0);
`ifdef ALARM_STICKY_EN
        exp = {1'b1, 1'b0, 1'b1, 8'd3, 8'd3};
`else
        exp = {1'b0, 1'b0, 1'b0, 8'd0, 8'd3};
`endif
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL last_cycle_after: got %h want %h", obs, exp);
        end
    endtask

`ifndef ALARM_STICKY_EN
    task automatic test_alarm_rehit();
        do_clr();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'd3, 8'd3}) begin
            errors++;
            $display("FAIL rehit_alarm: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'd3, 8'd3});
        end
        step(1'b1);
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 8'd1, 8'd4}) begin
            errors++;
            $display("FAIL rehit_open: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 8'd1, 8'd4});
        end
        step(1'b1);
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 8'd2, 8'd5}) begin
            errors++;
            $display("FAIL rehit_count: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 8'd2, 8'd5});
        end
    endtask
`else
    task automatic test_sticky();
        do_clr();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b1);
            checks++;
            if (alarm !== 1'b1) begin
                errors++;
                $display("FAIL sticky_hold i=%0d: got alarm=%0b want 1", i, alarm);
            end
        end
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'd3, 8'd255}) begin
            errors++;
            $display("FAIL sticky_sat: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'd3, 8'd255});
        end
        clr = 1'b1;
        step(1'b1);
        clr = 1'b0;
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL sticky_clr: got %h want %h", obs, 19'd0);
        end
    endtask
`endif

    task automatic test_rst_mid();
        do_clr();
        for (int c = 0; c <= 6; c++) step(c == 0 || c == 3);
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 8'd2, 8'd2}) begin
            errors++;
            $display("FAIL rst_mid_pre: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 8'd2, 8'd2});
        end
        hit = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got %h want %h", obs, 19'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1'b0);
            checks++;
            if (obs !== 19'd0) begin
                errors++;
                $display("FAIL rst_mid_quiet c=%0d: got %h want %h", c, obs, 19'd0);
            end
        end
        step(1'b1);
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL rst_mid_rehit: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 8'd1, 8'd1});
        end
    endtask

    task automatic test_clr_hit();
        do_clr();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 8'd2, 8'd2}) begin
            errors++;
            $display("FAIL clr_hit_pre: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 8'd2, 8'd2});
        end
        clr = 1'b1;
        step(1'b1);
        clr = 1'b0;
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL clr_hit: got %h want %h", obs, 19'd0);
        end
        step(1'b0);
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL clr_hit_idle: got %h want %h", obs, 19'd0);
        end
    endtask

    task automatic test_saturation();
        do_clr();
        for (int i = 0; i < 254; i++) step(1'b1);
        checks++;
        if (total_hits !== 8'd254) begin
            errors++;
            $display("FAIL total_254: got %0d want 254", total_hits);
        end
        for (int i = 0; i < 46; i++) step(1'b1);
        checks++;
        if (total_hits !== 8'd255) begin
            errors++;
            $display("FAIL total_sat: got %0d want 255", total_hits);
        end
        do_clr();
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL sat_clr: got %h want %h", obs, 19'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alarm();
        test_expire();
        test_last_cycle();
`ifndef ALARM_STICKY_EN
        test_alarm_rehit();
`else
        test_sticky();
`endif
        test_rst_mid();
        test_clr_hit();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hit_window_monitor

// File: doc/hit_window_monitor.md
HIT_WINDOW_MONITOR -- requirements
Module: hit_window_monitor

Interface
REQ-001 Parameter WINDOW, default 16; window length in sampled clock cycles; legal range 2..255.
REQ-002 Parameter THRESH, default 3; hits within one window that raise an alarm; legal range 2..WINDOW.
REQ-003 Port clk, input, 1; sole clock; all state updates on the posedge.
REQ-004 Port rst, input, 1; asynchronous, active-low reset.
REQ-005 Port hit, input, 1; detection flag from the upstream 101 sequence detector; each sampled high cycle is one detection.
REQ-006 Port clr, input, 1; synchronous clear.
REQ-007 Port alarm, output, 1; high while the FSM is in ALARM.
REQ-008 Port win_exp, output, 1; one-cycle pulse when a window closes without an alarm.
REQ-009 Port hit_cnt, output, 8; count of hits in the current window.
REQ-010 Port total_hits, output, 8; saturating count of all hits since reset or clr.
REQ-011 Port busy, output, 1; high in WIN or ALARM.

Function
REQ-012 The FSM SHALL have three states: IDLE, WIN and ALARM.
REQ-013 All outputs SHALL be registered or decoded from state only (Moore); there is no combinational path from hit to any output.
REQ-014 IDLE, hit=1: go to WIN; set hit_cnt=1 and window timer=0. IDLE, hit=0: stay in IDLE.
REQ-015 WIN: timer increments on every edge; each sampled hit increments hit_cnt.
REQ-016 WIN: when hit_cnt+hit reaches THRESH at an edge, the next state SHALL be ALARM.
REQ-017 WIN: the window spans exactly WINDOW sampled cycles, counted from the opening hit (timer 0..WINDOW-1).
REQ-018 WIN, at the edge sampling timer=WINDOW-1 with the threshold not reached: go to IDLE, clear hit_cnt, and pulse win_exp high for the following cycle.
REQ-019 If the threshold is reached on the last window cycle, ALARM SHALL take precedence and win_exp SHALL stay low.
REQ-020 The window SHALL be fixed, not sliding: hits after expiry never count toward the closed window.
REQ-021 In IDLE after expiry, a hit SHALL open a new window on the same edge the FSM samples it.
REQ-022 total_hits SHALL increment on every sampled hit in any state and saturate at 255.
REQ-023 hit_cnt SHALL saturate at 255.
REQ-024 clr=1 SHALL force IDLE and zero hit_cnt, total_hits and the timer on that edge.
REQ-025 clr SHALL take priority over hit; a hit sampled together with clr is discarded.

Reset
REQ-026 rst low SHALL immediately force IDLE, independent of clk.
REQ-027 rst low SHALL immediately force alarm=0, win_exp=0, busy=0, hit_cnt=0, total_hits=0 and timer=0.
REQ-028 rst asserted mid-window or in ALARM SHALL abandon the window with no win_exp pulse.
REQ-029 After rst deasserts, the first edge SHALL sample hit normally.

Configuration
REQ-030 Macro ALARM_STICKY_EN selects alarm behaviour.
REQ-031 With ALARM_STICKY_EN defined: ALARM holds until clr or rst; hits are still counted in total_hits but do not open new windows.
REQ-032 Without ALARM_STICKY_EN: ALARM lasts exactly one cycle, then the FSM returns to IDLE with hit_cnt cleared.
REQ-033 Without ALARM_STICKY_EN: a hit sampled during the ALARM cycle SHALL open a new window (hit_cnt=1).

Structure
REQ-034 State encodings (IDLE=2'b00, WIN=2'b01, ALARM=2'b10) and the 8-bit counter width constant SHALL live in shared package fsm_pkg.
REQ-035 The saturating 8-bit counter SHALL be sub-module sat_counter (inc, clr, q); it is instantiated for hit_cnt and total_hits.

Verification (WINDOW=16, THRESH=3; cycle 0 = first sampled hit)
REQ-036 Hits at cycles 0, 5, 10 -> alarm=1 from cycle 11; hit_cnt=3; win_exp stays 0.
REQ-037 Hits at cycles 0, 8, 16 -> win_exp=1 in cycle 16 only; the hit at cycle 16 opens a new window with hit_cnt=1 and total_hits=3.
REQ-038 Hits at cycles 0, 1, 15 -> ALARM entered with no win_exp pulse (precedence of REQ-019).
REQ-039 Sticky build: alarm held, 300 further hits, then clr -> alarm stays 1 and total_hits=255 until clr; clr returns all outputs to 0 and the FSM to IDLE.
REQ-040 rst pulsed low mid-window at cycle 7 with hit_cnt=2 -> all outputs 0 immediately, asynchronously; no win_exp; the next hit gives hit_cnt=1.
REQ-041 clr and hit high together in WIN -> IDLE, hit_cnt=0, total_hits=0.
